// File: rtl/sha_mem_pkg.sv
// Shared types and constants for the sha256 memory responder.
// Holds the responder FSM encoding, word widths and a width helper.
package sha_mem_pkg;

    localparam int unsigned WORD_W     = 32;
    localparam int unsigned ADDR_W     = 16;
    localparam int unsigned HASH_WORDS = 8;

    typedef enum logic [2:0] {
        StLoad,
        StStart,
        StWaitBusy,
        StWaitDone,
        StDrain
    } resp_state_e;

    // Counter width for a 0..n-1 range, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sha_word_ram.sv
// Register-array word RAM: one write port, one registered read port, one async read port.
// The whole array is cleared by the asynchronous reset.
module sha_word_ram
    import sha_mem_pkg::*;
#(
    parameter int unsigned Depth = 64,
    parameter int unsigned AddrW = cnt_width(Depth)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              we_i,
    input  logic [AddrW-1:0]  waddr_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic              rvalid_i,
    input  logic [AddrW-1:0]  raddr_i,
    output logic [WORD_W-1:0] rdata_o,
    input  logic [AddrW-1:0]  araddr_i,
    output logic [WORD_W-1:0] ardata_o
);

    logic [WORD_W-1:0] mem_q [Depth];
    logic [WORD_W-1:0] rdata_q;

    // Non-blocking update gives old data on a same-address read-during-write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
            rdata_q <= '0;
        end else begin
            if (we_i) begin
                mem_q[waddr_i] <= wdata_i;
            end
            rdata_q <= rvalid_i ? mem_q[raddr_i] : '0;
        end
    end

    assign rdata_o  = rdata_q;
    assign ardata_o = mem_q[araddr_i];

endmodule

// File: rtl/sha256_mem_responder.sv
// Memory-side responder for the sha256 core: loads the message from a host stream, kicks the
// core, serves its word-addressed memory port, then streams the eight hash words back.
module sha256_mem_responder
    import sha_mem_pkg::*;
#(
    parameter int unsigned NUM_OF_WORDS = 20,
    parameter int unsigned DEPTH        = 64,
    parameter int unsigned MSG_BASE     = 0,
    parameter int unsigned OUT_BASE     = 32,
    parameter int unsigned TIMEOUT      = 4096
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    output logic              in_ready,
    output logic              hash_valid,
    output logic [WORD_W-1:0] hash_data,
    output logic              hash_last,
    input  logic              hash_ready,
    output logic              core_start,
    output logic [ADDR_W-1:0] core_message_addr,
    output logic [ADDR_W-1:0] core_output_addr,
    input  logic              core_done,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [WORD_W-1:0] mem_write_data,
    output logic [WORD_W-1:0] mem_read_data,
    output logic              timeout_err,
    output logic              addr_err
);

    localparam int unsigned AddrW = cnt_width(DEPTH);
    localparam int unsigned CntW  = cnt_width(NUM_OF_WORDS);
    localparam int unsigned KW    = cnt_width(HASH_WORDS);
    localparam int unsigned TmrW  = cnt_width(TIMEOUT);

    if (MSG_BASE + NUM_OF_WORDS > OUT_BASE) begin : g_chk_msg
        $fatal(1, "message region overlaps hash region");
    end
    if (OUT_BASE + HASH_WORDS > DEPTH) begin : g_chk_out
        $fatal(1, "hash region exceeds RAM depth");
    end

    resp_state_e       state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [KW-1:0]     k_q, k_d;
    logic [TmrW-1:0]   tmr_q, tmr_d;
    logic              timeout_err_q, timeout_err_d;
    logic              addr_err_q;

    logic              mem_oob;
    logic              ram_we;
    logic [AddrW-1:0]  ram_waddr;
    logic [WORD_W-1:0] ram_wdata;
    logic [WORD_W-1:0] ram_ardata;

    assign mem_oob = 32'(mem_addr) >= DEPTH;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StLoad;
            cnt_q         <= '0;
            k_q           <= '0;
            tmr_q         <= '0;
            timeout_err_q <= 1'b0;
            addr_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            k_q           <= k_d;
            tmr_q         <= tmr_d;
            timeout_err_q <= timeout_err_d;
            addr_err_q    <= addr_err_q | mem_oob;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        k_d           = k_q;
        tmr_d         = tmr_q;
        timeout_err_d = timeout_err_q;
        unique case (state_q)
            StLoad: begin
                if (in_valid) begin
                    if (cnt_q == CntW'(NUM_OF_WORDS - 1)) begin
                        cnt_d   = '0;
                        state_d = StStart;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StStart: begin
                tmr_d   = '0;
                state_d = StWaitBusy;
            end
            StWaitBusy, StWaitDone: begin
                // Busy phase waits for done to drop, done phase waits for it to rise again.
                if ((state_q == StWaitBusy) && !core_done) begin
                    tmr_d   = '0;
                    state_d = StWaitDone;
                end else if ((state_q == StWaitDone) && core_done) begin
                    k_d     = '0;
                    state_d = StDrain;
                end else if (tmr_q == TmrW'(TIMEOUT - 1)) begin
                    timeout_err_d = 1'b1;
                    state_d       = StLoad;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            StDrain: begin
                if (hash_ready) begin
                    k_d = k_q + 1'b1;
                    if (k_q == KW'(HASH_WORDS - 1)) begin
                        state_d = StLoad;
                    end
                end
            end
            default: state_d = StLoad;
        endcase
    end

    // Host owns the write port while loading; the core only while it is running.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = '0;
        ram_wdata = '0;
        unique case (state_q)
            StLoad: begin
                ram_we    = in_valid;
                ram_waddr = AddrW'(MSG_BASE) + AddrW'(cnt_q);
                ram_wdata = in_data;
            end
            StWaitBusy, StWaitDone: begin
                ram_we    = mem_we && !mem_oob;
                ram_waddr = mem_addr[AddrW-1:0];
                ram_wdata = mem_write_data;
            end
            default: ;
        endcase
    end

    sha_word_ram #(
        .Depth (DEPTH),
        .AddrW (AddrW)
    ) u_ram (
        .clk      (clk),
        .reset_n  (reset_n),
        .we_i     (ram_we),
        .waddr_i  (ram_waddr),
        .wdata_i  (ram_wdata),
        .rvalid_i (!mem_oob),
        .raddr_i  (mem_addr[AddrW-1:0]),
        .rdata_o  (mem_read_data),
        .araddr_i (AddrW'(OUT_BASE) + AddrW'(k_q)),
        .ardata_o (ram_ardata)
    );

    assign in_ready          = (state_q == StLoad);
    assign core_start        = (state_q == StStart);
    assign hash_valid        = (state_q == StDrain);
    assign hash_last         = hash_valid && (k_q == KW'(HASH_WORDS - 1));
    assign hash_data         = hash_valid ? ram_ardata : '0;
    assign core_message_addr = ADDR_W'(MSG_BASE);
    assign core_output_addr  = ADDR_W'(OUT_BASE);
    assign timeout_err       = timeout_err_q;
    assign addr_err          = addr_err_q;

endmodule

// File: tb/tb_sha256_mem_responder.sv
// Scoreboard bench for sha256_mem_responder: a core BFM plus a word-array model of the RAM
// supplies expected hash beats; a negedge monitor checks every accepted beat and stall stability.
module tb_sha256_mem_responder;

    localparam int unsigned NW       = 20;
    localparam int unsigned DEPTH    = 64;
    localparam int unsigned OUT_BASE = 32;
    localparam int unsigned TIMEOUT  = 4096;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready;
    logic        hash_valid;
    logic [31:0] hash_data;
    logic        hash_last;
    logic        hash_ready = 1'b0;
    logic        core_start;
    logic [15:0] core_message_addr;
    logic [15:0] core_output_addr;
    logic        core_done = 1'b1;
    logic        mem_we = 1'b0;
    logic [15:0] mem_addr = '0;
    logic [31:0] mem_write_data = '0;
    logic [31:0] mem_read_data;
    logic        timeout_err;
    logic        addr_err;

    sha256_mem_responder dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .in_valid          (in_valid),
        .in_data           (in_data),
        .in_ready          (in_ready),
        .hash_valid        (hash_valid),
        .hash_data         (hash_data),
        .hash_last         (hash_last),
        .hash_ready        (hash_ready),
        .core_start        (core_start),
        .core_message_addr (core_message_addr),
        .core_output_addr  (core_output_addr),
        .core_done         (core_done),
        .mem_we            (mem_we),
        .mem_addr          (mem_addr),
        .mem_write_data    (mem_write_data),
        .mem_read_data     (mem_read_data),
        .timeout_err       (timeout_err),
        .addr_err          (addr_err)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_mem [DEPTH];
    logic [32:0] exp_q [$];      // {last, data}
    logic [32:0] exp_beat;
    logic        hold_v = 1'b0;
    logic [31:0] hold_d = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        exp_q.delete();
    endtask

    // Monitor: an accept is valid&&ready seen mid-cycle, completing at the next posedge.
    always @(negedge clk) begin
        if (hash_valid) begin
            if (hold_v) check("hash_stable", hash_data, hold_d);
            if (hash_ready) begin
                hold_v = 1'b0;
                if (exp_q.size() == 0) begin
                    check("hash_unexpected", 32'(hash_valid), 32'd0);
                end else begin
                    exp_beat = exp_q.pop_front();
                    check("hash_data", hash_data, exp_beat[31:0]);
                    check("hash_last", 32'(hash_last), 32'(exp_beat[32]));
                end
            end else begin
                hold_v = 1'b1;
                hold_d = hash_data;
            end
        end else begin
            hold_v = 1'b0;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            hash_ready = ($urandom_range(0, 2) != 0);
        end
    end

    task automatic load_msg(input logic [31:0] base);
        for (int i = 0; i < NW; i++) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
            check("load_in_ready", 32'(in_ready), 32'd1);
            in_valid = 1'b1;
            in_data  = base + i;
            model_mem[i] = base + i;
            tick();
            if (i < NW - 1) check("start_early", 32'(core_start), 32'd0);
        end
        in_valid = 1'b0;
        check("start_pulse", 32'(core_start), 32'd1);
        check("in_ready_busy", 32'(in_ready), 32'd0);
        tick();
        check("start_one_cycle", 32'(core_start), 32'd0);
    endtask

    task automatic core_write(input logic [15:0] a, input logic [31:0] d, input bit honoured);
        mem_addr       = a;
        mem_we         = 1'b1;
        mem_write_data = d;
        tick();
        mem_we = 1'b0;
        if (honoured && a < DEPTH) model_mem[a] = d;
    endtask

    task automatic core_read(input string name, input logic [15:0] a);
        mem_addr = a;
        mem_we   = 1'b0;
        tick();
        check(name, mem_read_data, (a < DEPTH) ? model_mem[a] : 32'd0);
    endtask

    // Core BFM: done drops after start, hash words written, done raised; beats queued for the monitor.
    task automatic core_run(input int mode);
        logic [31:0] v;
        tick();
        core_done = 1'b0;
        tick();
        if (mode == 0) begin
            core_write(16'd33, 32'hDEADBEEF, 1'b1);
            core_read("read_after_write", 16'd33);
            core_read("msg_word0", 16'd0);
            core_read("msg_word19", 16'd19);
            core_write(16'd34, 32'h12345678, 1'b1);
            mem_addr       = 16'd34;
            mem_we         = 1'b1;
            mem_write_data = 32'hA5A5A5A5;
            tick();
            mem_we = 1'b0;
            check("rdw_old_data", mem_read_data, 32'h12345678);
            model_mem[34] = 32'hA5A5A5A5;
            core_read("rdw_new_data", 16'd34);
        end
        if (mode == 2) begin
            core_read("oob_read", 16'd64);
            check("addr_err_set", 32'(addr_err), 32'd1);
            mem_addr = 16'd0;
        end
        for (int k = 0; k < 8; k++) begin
            v = (mode == 0) ? 32'h11111111 * k : $urandom;
            core_write(16'(OUT_BASE + k), v, 1'b1);
        end
        mem_addr = 16'd0;
        for (int k = 0; k < 8; k++) exp_q.push_back({(k == 7), model_mem[OUT_BASE + k]});
        core_done = 1'b1;
    endtask

    task automatic wait_queue(input int target);
        int n = 0;
        while (exp_q.size() > target && n < 300) begin
            tick();
            n++;
        end
        if (exp_q.size() > target) check("drain_timeout", 32'(exp_q.size()), 32'(target));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        clear_model();
        #2;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_hash_valid", 32'(hash_valid), 32'd0);
        check("rst_core_start", 32'(core_start), 32'd0);
        check("rst_msg_addr", 32'(core_message_addr), 32'd0);
        check("rst_out_addr", 32'(core_output_addr), 32'd32);
        #10;
        reset_n = 1'b1;
        tick();
        check("init_in_ready", 32'(in_ready), 32'd1);

        // Run 1 with memory port checks, then run 2 back-to-back.
        load_msg(32'h100);
        core_run(0);
        wait_queue(0);
        check("run1_back_to_load", 32'(in_ready), 32'd1);
        core_write(16'd40, 32'h0BAD0BAD, 1'b0);
        core_read("idle_write_dropped", 16'd40);

        load_msg(32'h200);
        core_run(1);
        wait_queue(0);
        check("run2_back_to_load", 32'(in_ready), 32'd1);
        check("run2_timeout_err", 32'(timeout_err), 32'd0);
        check("run2_addr_err", 32'(addr_err), 32'd0);

        // Run 3: out-of-range access, then reset in the middle of the drain.
        load_msg(32'h300);
        core_run(2);
        wait_queue(5);
        reset_n = 1'b0;
        #1;
        check("midrst_hash_valid", 32'(hash_valid), 32'd0);
        check("midrst_core_start", 32'(core_start), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_timeout_err", 32'(timeout_err), 32'd0);
        check("midrst_addr_err", 32'(addr_err), 32'd0);
        check("midrst_rdata", mem_read_data, 32'd0);
        clear_model();
        #1;
        reset_n = 1'b1;
        tick();
        core_read("ram_cleared", 16'd32);

        // Timeout: done never drops after start.
        load_msg(32'h400);
        n = 0;
        while (!timeout_err && n < TIMEOUT + 20) begin
            tick();
            n++;
        end
        check("timeout_cycles", 32'(n), 32'(TIMEOUT));
        check("timeout_err", 32'(timeout_err), 32'd1);
        check("timeout_in_load", 32'(in_ready), 32'd1);
        repeat (3) tick();
        check("timeout_sticky", 32'(timeout_err), 32'd1);
        check("timeout_no_hash", 32'(hash_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
